// File: rtl/zsy_seg_pkg.sv
// Shared definitions for the seven-segment capture path: segment codes,
// capture FSM encoding and the digit count.
package zsy_seg_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-high segment codes, bit 6 = a ... bit 0 = g
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/zsy_seg_dec.sv
// Seven-segment pattern to hex nibble decoder; patterns outside the table
// return nibble 0 with the invalid flag set.
module zsy_seg_dec
  import zsy_seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] nib,
  output logic       invalid
);

  always_comb begin
    nib     = 4'h0;
    invalid = 1'b0;
    case (pat)
      SEG_0:   nib = 4'h0;
      SEG_1:   nib = 4'h1;
      SEG_2:   nib = 4'h2;
      SEG_3:   nib = 4'h3;
      SEG_4:   nib = 4'h4;
      SEG_5:   nib = 4'h5;
      SEG_6:   nib = 4'h6;
      SEG_7:   nib = 4'h7;
      SEG_8:   nib = 4'h8;
      SEG_9:   nib = 4'h9;
      SEG_A:   nib = 4'hA;
      SEG_B:   nib = 4'hB;
      SEG_C:   nib = 4'hC;
      SEG_D:   nib = 4'hD;
      SEG_E:   nib = 4'hE;
      SEG_F:   nib = 4'hF;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/zsy_seg_capture.sv
// Display-side monitor: samples a scanned four-digit seven-segment bus, waits
// for each strobe to settle, decodes the digits and publishes whole frames.
module zsy_seg_capture
  import zsy_seg_pkg::*;
#(
  parameter int SETTLE         = 4,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic        CP,
  input  logic        MR,
  input  logic [6:0]  Y,
  input  logic        dp,
  input  logic        dig1,
  input  logic        dig2,
  input  logic        dig3,
  input  logic        dig4,
  output logic [15:0] val,
  output logic [3:0]  dps,
  output logic        frame_vld,
  output logic        frame_err,
  output logic        pat_err,
  output logic        sel_err
);

  // Raw pin levels meaning "not selected" / "unlit"; XOR with these normalises.
  localparam logic [NUM_DIGITS-1:0] DIG_IDLE = (DIG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]            SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic                  DP_IDLE  = (SEG_ACTIVE_LOW != 0);
  localparam logic [3:0]            SETTLE_N = 4'(SETTLE);

  logic [NUM_DIGITS-1:0]   dig_p0, sel, cur_sel, cur_sel_d;
  logic [6:0]              y_p0, seg;
  logic                    dp_p0, dp_n;
  logic                    sel_one, sel_multi;
  state_t                  state, state_d;
  logic [3:0]              cnt, cnt_d;
  logic                    start, capture;
  logic [3:0]              dec_nib;
  logic                    dec_bad;
  logic [4*NUM_DIGITS-1:0] slot_nib, nib_w;
  logic [NUM_DIGITS-1:0]   slot_dp, dp_w, slot_err, err_w, mask, mask_w;
  logic                    done;

  // ---- p0: input register, reset to the inactive pin levels
  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      dig_p0 <= DIG_IDLE;
      y_p0   <= SEG_IDLE;
      dp_p0  <= DP_IDLE;
    end else begin
      dig_p0 <= {dig1, dig2, dig3, dig4};
      y_p0   <= Y;
      dp_p0  <= dp;
    end
  end

  assign sel       = dig_p0 ^ DIG_IDLE;
  assign seg       = y_p0 ^ SEG_IDLE;
  assign dp_n      = dp_p0 ^ DP_IDLE;
  assign sel_one   = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  assign sel_multi = (sel != '0) && !sel_one;

  zsy_seg_dec u_dec (
    .pat     (seg),
    .nib     (dec_nib),
    .invalid (dec_bad)
  );

  // ---- p1: settle FSM; a new one-hot selection always restarts the count
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    cur_sel_d = cur_sel;
    start     = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: start = sel_one;
      ST_SETTLE: begin
        if (!sel_one) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (sel != cur_sel) begin
          start = 1'b1;
        end else begin
          cnt_d = cnt + 4'd1;
          if (cnt + 4'd1 == SETTLE_N) begin
            capture = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!sel_one) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (sel != cur_sel) begin
          start = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (start) begin
      cur_sel_d = sel;
      cnt_d     = 4'd1;
      if (SETTLE_N == 4'd1) begin
        capture = 1'b1;
        state_d = ST_HOLD;
      end else begin
        state_d = ST_SETTLE;
      end
    end
  end

  // Working slots merged with the digit captured this cycle
  always_comb begin
    nib_w = slot_nib;
    dp_w  = slot_dp;
    err_w = slot_err;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (capture && sel[i]) begin
        nib_w[4*i +: 4] = dec_nib;
        dp_w[i]         = dp_n;
        err_w[i]        = dec_bad;
      end
    end
    mask_w = capture ? (mask | sel) : mask;
    done   = capture && (mask_w == '1);
  end

  always_ff @(posedge CP) begin
    slot_nib <= nib_w;
    slot_dp  <= dp_w;
    slot_err <= err_w;
  end

  // ---- p2: control state and registered outputs
  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      cur_sel   <= '0;
      mask      <= '0;
      val       <= 16'h0000;
      dps       <= '0;
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
      pat_err   <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cur_sel   <= cur_sel_d;
      frame_vld <= done;
      pat_err   <= capture && dec_bad;
      sel_err   <= sel_multi;
      if (done) begin
        mask      <= '0;
        val       <= nib_w;
        dps       <= dp_w;
        frame_err <= |err_w;
      end else begin
        mask <= mask_w;
      end
    end
  end

endmodule

// File: doc/zsy_seg_capture.md
# zsy_seg_capture

Receive-side counterpart of the team's four-digit multiplexed seven-segment driver. The block samples the scanned segment bus (`Y`, `dp`) and the digit strobes (`dig1`..`dig4`), and waits for each strobe to settle. It decodes each digit's pattern back to a 4-bit hex value and publishes a complete 16-bit frame once all four digits have been captured. It sits in benches and self-checking top levels as the display-side monitor, so the displayed values can be compared numerically.

## Interface
- `SETTLE`, default 4: number of consecutive cycles a strobe must be stable before its digit is captured; legal range 1..15.
- `DIG_ACTIVE_LOW`, default 1: 1 means a strobe selects its digit when at 0; 0 means selected when at 1.
- `SEG_ACTIVE_LOW`, default 0: 1 means segments and `dp` are lit at 0.
- `CP`, input, 1 bit: clock; all state changes on the rising edge.
- `MR`, input, 1 bit: reset, asynchronous, active-low.
- `Y`, input, 7 bits: segment bus; `Y[6]`=a, `Y[5]`=b, … `Y[0]`=g.
- `dp`, input, 1 bit: decimal point of the currently strobed digit.
- `dig1`..`dig4`, input, 1 bit each: digit strobes; `dig1` is the most significant digit.
- `val`, output, 16 bits: last complete frame; `val[15:12]` is dig1 and `val[3:0]` is dig4.
- `dps`, output, 4 bits: decimal points of the last frame; `dps[3]` is dig1.
- `frame_vld`, output, 1 bit: one-cycle pulse when `val`/`dps` update.
- `frame_err`, output, 1 bit: set with each frame if any of its digits failed decode; held until the next frame.
- `pat_err`, output, 1 bit: one-cycle pulse on a capture whose pattern is not in the table.
- `sel_err`, output, 1 bit: one-cycle pulse when more than one strobe is active in the registered inputs.

## Operation
- Input stage:
  - All inputs are registered once.
  - Polarity is normalised to active-high after the register.
  - Decisions use only the registered copies.
- Select vector `sel[3:0]` = {dig1..dig4} after normalisation.
  - Zero bits set: no digit selected.
  - More than one bit set: `sel_err` pulses, the cycle is treated as no selection, and the FSM returns to IDLE.
- FSM states:
  - IDLE: no selection. On a one-hot `sel`, go to SETTLE with `cnt`=1.
  - SETTLE: while `sel` is unchanged, `cnt` increments. When `cnt` equals `SETTLE`, capture and go to HOLD. If `sel` changes to another one-hot value, restart with `cnt`=1. If `sel` goes to zero or multi-hot, go to IDLE.
  - HOLD: no further captures of this digit. A change to another one-hot value goes to SETTLE with `cnt`=1; zero or multi-hot goes to IDLE.
- When `SETTLE`=1, the capture happens in the same edge as the IDLE→SETTLE transition, and the FSM lands directly in HOLD.
- A capture writes the decoded nibble, the `dp` bit and the error bit into that digit's working slot, and sets that digit's bit in `mask[3:0]`.
- Recapturing a digit before the frame completes overwrites its slot; the mask bit is already set.
- Decode table (active-high, a..g): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111. Any other pattern decodes to nibble 0, sets the slot's error bit and pulses `pat_err`.
- Frame completion: the edge on which `mask` would become 4'b1111 does all of the following together:
  - copies the working slots, including the digit just captured, to `val`/`dps`;
  - sets `frame_err` to the OR of the slot error bits;
  - asserts `frame_vld` for one cycle;
  - clears `mask` to 0.

## Timing
- Reset values: `val`=16'h0000, `dps`=0, `frame_vld`=0, `frame_err`=0, `pat_err`=0, `sel_err`=0, FSM=IDLE, `cnt`=0, `mask`=0, input registers 0 (normalised "not selected").
- Reset asserted in the middle of a frame discards the partial frame; the first frame after release needs all four digits again.
- Latency: a strobe first becomes active at pin edge t. The registered copy is seen at t+1, and capture happens at edge t+SETTLE. `pat_err` and `sel_err` are registered outputs visible in the cycle after the triggering edge. `frame_vld`, `val`, `dps` and `frame_err` are all visible in the cycle after the completing capture edge.
- A strobe held for fewer than `SETTLE` registered cycles is never captured.

## Structure
- Shared package `zsy_seg_pkg`:
  - the sixteen segment-code constants;
  - the FSM state encoding (IDLE, SETTLE, HOLD; 2 bits);
  - the digit-count constant 4.
- Sub-module `zsy_seg_dec`: combinational, 7-bit pattern in, 4-bit nibble plus invalid flag out. The same table is reusable by the driver side.
- The top level holds the input registers, FSM, settle counter, working slots, mask and output registers.

## Test plan
- **Frame 0x0209 decode.** Scan dig1..dig4 as patterns 1111110, 1101101, 1111110, 1111011, 8 cycles each, `SETTLE`=4. Required: one `frame_vld` pulse, `val`=16'h0209, `frame_err`=0.
- **Glitch rejection.** With `SETTLE`=4, strobe dig2 for 3 cycles only. Required: no capture, `mask` unchanged.
- **Invalid pattern.** Pattern 1010101 on dig3 inside a frame. Required: one `pat_err` pulse, then at frame completion `val[7:4]`=0 and `frame_err`=1.
- **Multi-hot select.** Drive dig1 and dig4 together. Required: one `sel_err` pulse, FSM goes to IDLE, no capture.
- **Reset mid-frame.** Capture 2 digits, pulse `MR` low asynchronously between edges, then run a full frame 0xABCD. Required: all outputs go to reset values immediately, then one `frame_vld` with `val`=16'hABCD.
- **Polarity and `dp`.** With `DIG_ACTIVE_LOW`=0 and `SEG_ACTIVE_LOW`=1, run the inverted frame "8.888". Required: `val`=16'h8888, `dps`=4'b1000.
